// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// One result bit per cycle: a 33-cycle latency from accept to HI/LO update, the same for every op.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_read,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    b_mag     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    // Multiply: the low half holds the unconsumed multiplier bits and shifts right each step.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: the partial remainder in the high half gains one dividend bit per step.
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge    = rem_sh >= {1'b0, opnd_q};
    rem_diff  = rem_sh[WIDTH-1:0] - opnd_q;

    prod_fix  = neg_quo_q ? -acc_q : acc_q;
    quo_fix   = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          busy_d     = 1'b1;
          cnt_d      = '0;
          is_div_d   = op[1];
          a_raw_d    = op_a;
          neg_quo_d  = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          neg_rem_d  = signed_op & op_a[WIDTH-1];
          div_zero_d = op[1] && (op_b == '0);
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
        if (is_div_q)
          acc_d = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
        else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (hilo_read | start);
  assign hi    = hi_q;
  assign lo    = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that services MULT, MULTU, DIV and DIVU requests issued by the execute stage and holds the 64-bit result in the HI/LO registers. The execute stage starts an operation and continues issuing unrelated instructions. This block tracks the operation and asserts `stall` back to the pipeline when a HI/LO read or a new request collides with an operation still in progress. It sits beside the ALU in EX. The EX stage is the initiator and this block is the responder of the start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `start`  in  1  request pulse; `op`, `op_a` and `op_b` are sampled when `start` is accepted.
- `op`  in  2  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `op_a`  in  WIDTH  multiplicand or dividend (rs).
- `op_b`  in  WIDTH  multiplier or divisor (rt).
- `mthi`, `mtlo`  in  1  write `wdata` into HI or LO.
- `wdata`  in  WIDTH  data for `mthi`/`mtlo`.
- `hilo_read`  in  1  an MFHI or MFLO is in EX this cycle.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse; HI and LO hold the new result.
- `stall`  out  1  combinational: `busy & (hilo_read | start)`.
- `hi`, `lo`  out  WIDTH  HI and LO registers, read directly by MFHI/MFLO.

## Operation
- States:
  - IDLE: waits for a request.
  - RUN: iterates with a 5-bit counter `cnt`.
  - FIX: applies sign correction and writes HI/LO.
- Transitions:
  - IDLE→RUN when `start` is high.
  - RUN→FIX when `cnt`==31.
  - FIX→IDLE unconditionally.
- On accept, the block latches the magnitudes: |op_a| and |op_b| for signed ops, the raw values for unsigned ops. It also latches `neg_q = a[31]^b[31]` and `neg_r = a[31]`, both forced to 0 for unsigned ops.
- Multiply:
  - Shift-add, one multiplier bit per RUN cycle, into a 64-bit accumulator.
  - FIX negates the 64-bit product (two's complement) if `neg_q`, then writes {hi,lo}.
- Divide:
  - Restoring division, one quotient bit per RUN cycle.
  - FIX negates the quotient if `neg_q`, negates the remainder if `neg_r`, then writes lo=quotient and hi=remainder.
- Divide by zero, signed or unsigned:
  - Result is lo=32'hFFFF_FFFF and hi=op_a as originally presented.
  - Latency is unchanged.
- Signed 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0 (wraps, no trap).
- `start` while `busy`: ignored; `stall` holds the requester until IDLE.
- `mthi`/`mtlo`:
  - In IDLE without `start`: the register is written at the next edge.
  - While `busy`, or in the same cycle as an accepted `start`: ignored.
- HI/LO change only in FIX, on `mthi`/`mtlo`, or on reset.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0.
- `rst` mid-operation aborts the operation. After the next edge the block is in IDLE with HI/LO=0, and no `done` pulse is produced.
- Accept edge E0: `start` high in IDLE; `busy`=1 from E0.
- RUN covers 32 cycles, edges E1..E32.
- FIX:
  - Is in effect after E32.
  - HI/LO are written at E33.
  - `done`=1 and `busy`=0 for the cycle after E33.
- Latency from accept to result visible on `hi`/`lo` is 33 cycles, identical for all ops.
- Back-to-back: `start` is accepted in the cycle where `done`=1, because the state is already IDLE.
- `stall` is combinational from `hilo_read`/`start` and is never asserted in IDLE.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → after 33 cycles hi=0xFFFF_FFFE, lo=0x0000_0001, `done` pulses exactly once.
- MULT −3 (0xFFFF_FFFD) × 5 → hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. MULT 0x8000_0000 × 0x8000_0000 → hi=0x4000_0000, lo=0.
- DIV −7 / 2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100 / 7 → lo=14, hi=2. DIVU 100 / 0 → lo=0xFFFF_FFFF, hi=0x64.
- Start MULTU 6×7 and hold `hilo_read`=1 → `stall`=1 for 33 cycles. A second `start` issued at cycle 10 is ignored. `mthi` issued at cycle 5 is ignored. Final hi=0, lo=42.
- Assert `rst` at cycle 15 of a DIV → next cycle `busy`=0 and hi=lo=0, with no `done` pulse. A new DIVU 9/3 then completes with lo=3, hi=0.
- In IDLE, `mthi` with wdata=0x1234 → hi=0x1234 next cycle. `mtlo` together with `start` → `mtlo` is dropped and the start proceeds.
